btn_event_ctrl: RTL and testbench

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce.sv | 38 +++
 rtl/btn_event_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types for the button event controller: event codes and per-button FSM states.
package btn_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_DOUBLE  = 2'd3
    } evt_code_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_WAIT_DBL  = 3'd3,
        ST_SECOND    = 3'd4
    } btn_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchronizer plus saturating counter; level is high only at full count.
// Latency: rise after 2 + (2^DEB_W - 1) cycles, fall 3 cycles after the raw input drops.
// Backpressure: none, free-running per button.
module btn_debounce #(
    parameter int DEB_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    logic [1:0]       sync_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync_q[1]) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q  <= cnt_d;
        end
    end

    assign level_o = &cnt_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Purpose: debounced buttons -> PRESS/RELEASE/LONG/DOUBLE events, round-robin onto one valid/ready port.
// Latency: evt_valid_o rises 2 cycles after a btn_level_o change when the output is free.
// Backpressure: evt_ready_i low holds the output; each button keeps one pending slot (newest wins). BTN_EVT_OVF_EN adds ovf_o/ovf_clr_i.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN    = 4,
    parameter int DEB_W    = 20,
    parameter int LONG_CYC = 50_000_000,
    parameter int DBL_CYC  = 12_500_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_i,
`ifdef BTN_EVT_OVF_EN
    output logic [N_BTN-1:0]         ovf_o,
    input  logic                     ovf_clr_i,
`endif
    output logic [N_BTN-1:0]         btn_level_o,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [$clog2(N_BTN)-1:0] evt_id_o,
    output logic [1:0]               evt_code_o
);

    localparam int IW   = $clog2(N_BTN);
    localparam int TMAX = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LONG_END = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] DBL_END  = TW'(DBL_CYC - 1);

    logic [N_BTN-1:0] lvl;

    for (genvar g = 0; g < N_BTN; g++) begin : g_deb
        btn_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (btn_i[g]),
            .level_o (lvl[g])
        );
    end

    assign btn_level_o = lvl;

    btn_state_e       st_q    [N_BTN];
    btn_state_e       st_d    [N_BTN];
    logic [TW-1:0]    tmr_q   [N_BTN];
    logic [TW-1:0]    tmr_d   [N_BTN];
    logic [N_BTN-1:0] ev_vld;
    evt_code_e        ev_code [N_BTN];

    // FSMs act on the level itself; each state implies the level seen on entry.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            st_d[i]    = st_q[i];
            tmr_d[i]   = tmr_q[i];
            ev_vld[i]  = 1'b0;
            ev_code[i] = EVT_PRESS;
            case (st_q[i])
                ST_IDLE: if (lvl[i]) begin
                    st_d[i]  = ST_PRESSED;
                    tmr_d[i] = '0;
                    ev_vld[i] = 1'b1;
                end
                ST_PRESSED: if (!lvl[i]) begin
                    st_d[i]    = ST_WAIT_DBL;
                    tmr_d[i]   = '0;
                    ev_vld[i]  = 1'b1;
                    ev_code[i] = EVT_RELEASE;
                end else if (tmr_q[i] == LONG_END) begin
                    st_d[i]    = ST_LONG_HELD;
                    ev_vld[i]  = 1'b1;
                    ev_code[i] = EVT_LONG;
                end else begin
                    tmr_d[i] = tmr_q[i] + 1'b1;
                end
                ST_LONG_HELD, ST_SECOND: if (!lvl[i]) begin
                    st_d[i]    = ST_IDLE;
                    ev_vld[i]  = 1'b1;
                    ev_code[i] = EVT_RELEASE;
                end
                ST_WAIT_DBL: if (lvl[i]) begin
                    st_d[i]    = ST_SECOND;
                    ev_vld[i]  = 1'b1;
                    ev_code[i] = EVT_DOUBLE;
                end else if (tmr_q[i] == DBL_END) begin
                    st_d[i] = ST_IDLE;
                end else begin
                    tmr_d[i] = tmr_q[i] + 1'b1;
                end
                default: st_d[i] = ST_IDLE;
            endcase
        end
    end

    logic [N_BTN-1:0] pend_q;
    evt_code_e        code_q [N_BTN];
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    rr_ptr_d;
    logic             out_vld_q;
    logic [IW-1:0]    out_id_q;
    logic [1:0]       out_code_q;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic             load;
    logic [N_BTN-1:0] take;
    int               arb_idx;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        arb_idx = 0;
        for (int k = 0; k < N_BTN; k++) begin
            arb_idx = (int'(rr_ptr_q) + k) % N_BTN;
            if (!win_vld && pend_q[arb_idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(arb_idx);
            end
        end
        load = win_vld && (!out_vld_q || evt_ready_i);
        take = '0;
        if (load) take[win_idx] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (load) rr_ptr_d = (int'(win_idx) == N_BTN - 1) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]   <= ST_IDLE;
                tmr_q[i]  <= '0;
                code_q[i] <= EVT_PRESS;
            end
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            out_vld_q  <= 1'b0;
            out_id_q   <= '0;
            out_code_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
                // A fresh event keeps the slot pending even if its old code is being loaded now.
                if (ev_vld[i]) begin
                    pend_q[i] <= 1'b1;
                    code_q[i] <= ev_code[i];
                end else if (take[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
            rr_ptr_q <= rr_ptr_d;
            if (!out_vld_q || evt_ready_i) begin
                out_vld_q <= win_vld;
                if (win_vld) begin
                    out_id_q   <= win_idx;
                    out_code_q <= code_q[win_idx];
                end
            end
        end
    end

`ifdef BTN_EVT_OVF_EN
    logic [N_BTN-1:0] ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_clr_i ? '0 : ovf_q) | (ev_vld & pend_q & ~take);
        end
    end

    assign ovf_o = ovf_q;
`endif

    assign evt_valid_o = out_vld_q;
    assign evt_id_o    = out_id_q;
    assign evt_code_o  = out_code_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with short debounce/timer parameters.
module tb_btn_event_ctrl;

    localparam int PRESS   = 0;
    localparam int RELEASE = 1;
    localparam int LONG    = 2;
    localparam int DOUBLE  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] level;
    logic       valid;
    logic       ready;
    logic [1:0] id;
    logic [1:0] code;
    logic [3:0] ovf;
    logic       ovf_clr;

    btn_event_ctrl #(
        .N_BTN(4), .DEB_W(4), .LONG_CYC(100), .DBL_CYC(40)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn),
`ifdef BTN_EVT_OVF_EN
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr),
`endif
        .btn_level_o (level),
        .evt_valid_o (valid),
        .evt_ready_i (ready),
        .evt_id_o    (id),
        .evt_code_o  (code)
    );

`ifndef BTN_EVT_OVF_EN
    assign ovf = 4'b0000;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int code;
        int cyc;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         rise_cyc[4];
    logic [3:0] lvl_prev = 4'b0000;
    logic [3:0] seen = 4'b0000;
    int         n_chk = 0;
    int         n_err = 0;

    always @(posedge clk) cyc++;

    // Records every accepted handshake and each debounced rising edge.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && valid && ready) begin
            e.id   = int'(id);
            e.code = int'(code);
            e.cyc  = cyc;
            q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            if (level[i] && !lvl_prev[i]) rise_cyc[i] = cyc;
            if (level[i]) seen[i] = 1'b1;
        end
        lvl_prev = level;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pop_ev(input string tag, input int exp_id, input int exp_code, output int c);
        ev_t e;
        n_chk++;
        c = -1000;
        if (q.size() == 0) begin
            n_err++;
            $error("FAIL %s: no event, expected id%0d code%0d", tag, exp_id, exp_code);
        end else begin
            e = q.pop_front();
            c = e.cyc;
            assert (e.id == exp_id && e.code == exp_code)
            else begin
                n_err++;
                $error("FAIL %s: got id%0d code%0d expected id%0d code%0d",
                       tag, e.id, e.code, exp_id, exp_code);
            end
        end
    endtask

    initial begin
        int c0, c1, c2, c3;
        rst_n = 1'b0; btn = 4'b0000; ready = 1'b1; ovf_clr = 1'b0;
        step(3);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_id",    32'(id), 0);
        chk("rst_code",  32'(code), 0);
        rst_n = 1'b1;
        step(2);

        // Short press on button 1
        btn[1] = 1'b1;
        step(16);
        chk("deb_not_yet", 32'(level[1]), 0);
        step(1);
        chk("deb_done", 32'(level[1]), 1);
        step(13);
        btn[1] = 1'b0;
        step(60);
        pop_ev("short_press", 1, PRESS, c0);
        chk("latency", 32'(c0 - rise_cyc[1]), 2);
        pop_ev("short_release", 1, RELEASE, c1);
        chk("short_no_extra", 32'(q.size()), 0);

        // Long press on button 2
        btn[2] = 1'b1;
        step(150);
        btn[2] = 1'b0;
        step(20);
        pop_ev("long_press", 2, PRESS, c0);
        pop_ev("long_long", 2, LONG, c1);
        chk("long_delay", 32'(c1 - c0), 100);
        pop_ev("long_release", 2, RELEASE, c2);
        chk("long_no_extra", 32'(q.size()), 0);

        // Double click on button 0
        btn[0] = 1'b1; step(20);
        btn[0] = 1'b0; step(10);
        btn[0] = 1'b1; step(20);
        btn[0] = 1'b0; step(20);
        pop_ev("dbl_press", 0, PRESS, c0);
        pop_ev("dbl_release1", 0, RELEASE, c1);
        pop_ev("dbl_double", 0, DOUBLE, c2);
        pop_ev("dbl_release2", 0, RELEASE, c3);
        chk("dbl_no_extra", 32'(q.size()), 0);

        // Bouncing button 3
        seen[3] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            btn[3] = ~btn[3];
            step(5);
        end
        step(10);
        chk("bounce_level", 32'(level[3]), 0);
        chk("bounce_seen", 32'(seen[3]), 0);
        chk("bounce_no_evt", 32'(q.size()), 0);

        // Arbitration with backpressure, pointer freshly reset
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; step(2);
        ready = 1'b0;
        btn = 4'b1111;
        step(19);
        chk("arb_hold_a", 32'({valid, id, code}), 32'b1_00_00);
        step(8);
        chk("arb_hold_b", 32'({valid, id, code}), 32'b1_00_00);
        ready = 1'b1;
        step(6);
        pop_ev("arb_0", 0, PRESS, c0);
        pop_ev("arb_1", 1, PRESS, c1);
        pop_ev("arb_2", 2, PRESS, c2);
        pop_ev("arb_3", 3, PRESS, c3);
        chk("arb_throughput", 32'(c3 - c0), 3);
        btn = 4'b0000;
        step(30);
        pop_ev("arb_rel_0", 0, RELEASE, c0);
        pop_ev("arb_rel_1", 1, RELEASE, c0);
        pop_ev("arb_rel_2", 2, RELEASE, c0);
        pop_ev("arb_rel_3", 3, RELEASE, c0);
        chk("arb_no_extra", 32'(q.size()), 0);
        step(45);

        // Overwrite: output busy with btn0 PRESS while btn1 presses and releases
        ready = 1'b0;
        btn[0] = 1'b1; step(19);
        btn[1] = 1'b1; step(30);
        btn[1] = 1'b0; step(10);
`ifdef BTN_EVT_OVF_EN
        chk("ovf_set", 32'(ovf), 32'b0010);
`endif
        ready = 1'b1;
        step(3);
        pop_ev("ovw_first", 0, PRESS, c0);
        pop_ev("ovw_second", 1, RELEASE, c1);
        chk("ovw_no_extra", 32'(q.size()), 0);
`ifdef BTN_EVT_OVF_EN
        ovf_clr = 1'b1; step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);
`endif

        // Reset in the middle of a hold
        ready = 1'b0;
        btn[2] = 1'b1;
        step(20);
        chk("pre_rst_out", 32'({valid, id, code}), 32'b1_10_00);
        chk("pre_rst_lvl", 32'(level), 32'b0101);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_id",    32'(id), 0);
        chk("mid_rst_code",  32'(code), 0);
        chk("mid_rst_ovf",   32'(ovf), 0);
        step(2);
        rst_n = 1'b1;
        step(16);
        chk("post_rst_deb_wait", 32'(level), 0);
        step(1);
        chk("post_rst_deb_done", 32'(level), 32'b0101);
        ready = 1'b1;
        step(4);
        pop_ev("post_rst_0", 0, PRESS, c0);
        pop_ev("post_rst_2", 2, PRESS, c1);
        chk("post_rst_no_extra", 32'(q.size()), 0);

        btn = 4'b0000;
        step(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
